// File: rtl/fxp2bf_conv.sv
// Signed fixed-point to floating-point converter: a serial leading-one search,
// then round-to-nearest-even, with a valid/ready handshake on both sides.
module fxp2bf_conv #(
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 7,
    parameter int MAN_WIDTH  = 7,
    parameter int EXP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [INT_WIDTH-1:0]  parte_intera,
    input  logic [FRAC_WIDTH-1:0] parte_frazionaria,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  sgn_o,
    output logic [EXP_WIDTH-1:0]  exp_o,
    output logic [MAN_WIDTH-1:0]  mantissa_o,
    output logic                  zero_o,
    output logic                  inexact_o
);

    localparam int W    = INT_WIDTH + FRAC_WIDTH;
    localparam int BIAS = 2**(EXP_WIDTH-1) - 1;
    localparam int PW   = $clog2(W);
    localparam int EW   = W + MAN_WIDTH + 1;
    localparam logic [EXP_WIDTH-1:0] EXP_OFF = EXP_WIDTH'(BIAS - FRAC_WIDTH);
    localparam logic [PW-1:0]        PTR_TOP = PW'(W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_ROUND, S_DONE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [PW-1:0]          r_ptr;
    logic [W-1:0]           r_mag;
    logic                   r_sgn;

    logic [W-1:0]           w_x, w_mag_in;
    logic                   w_accept;
    logic [W-1:0]           w_norm;
    logic [EW-1:0]          w_ext;
    logic [MAN_WIDTH-1:0]   w_man_t, w_man_r;
    logic                   w_guard, w_sticky, w_inc, w_carry;
    logic [EXP_WIDTH-1:0]   w_exp_t, w_exp_r;

    assign w_x      = {parte_intera, parte_frazionaria};
    assign w_mag_in = w_x[W-1] ? (-w_x) : w_x;
    assign w_accept = valid_i && (r_state == S_IDLE);

    assign ready_o  = (r_state == S_IDLE);
    assign valid_o  = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = (w_mag_in == '0) ? S_DONE : S_SEARCH;
            S_SEARCH: if (r_mag[r_ptr]) w_state_nxt = S_ROUND;
            S_ROUND:  w_state_nxt = S_DONE;
            S_DONE:   if (ready_i) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Normalise so the leading one sits at the MSB; the zero tail supplies
    // right-padding when fewer than MAN_WIDTH bits lie below the leading one.
    assign w_norm   = r_mag << (PTR_TOP - r_ptr);
    assign w_ext    = {w_norm, {(MAN_WIDTH+1){1'b0}}};
    assign w_man_t  = w_ext[EW-2 -: MAN_WIDTH];
    assign w_guard  = w_ext[EW-2-MAN_WIDTH];
    assign w_sticky = |(w_ext << (MAN_WIDTH + 2));
    assign w_inc    = w_guard & (w_sticky | w_man_t[0]);
    assign {w_carry, w_man_r} = {1'b0, w_man_t} + (MAN_WIDTH+1)'(w_inc);
    assign w_exp_t  = EXP_WIDTH'(r_ptr) + EXP_OFF;
    assign w_exp_r  = w_exp_t + EXP_WIDTH'(w_carry);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr      <= PTR_TOP;
            r_mag      <= '0;
            r_sgn      <= 1'b0;
            sgn_o      <= 1'b0;
            exp_o      <= '0;
            mantissa_o <= '0;
            zero_o     <= 1'b0;
            inexact_o  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mag <= w_mag_in;
                        r_sgn <= w_x[W-1];
                        r_ptr <= PTR_TOP;
                        if (w_mag_in == '0) begin
                            sgn_o      <= 1'b0;
                            exp_o      <= '0;
                            mantissa_o <= '0;
                            zero_o     <= 1'b1;
                            inexact_o  <= 1'b0;
                        end
                    end
                end
                S_SEARCH: begin
                    if (!r_mag[r_ptr]) r_ptr <= r_ptr - PW'(1);
                end
                S_ROUND: begin
                    sgn_o      <= r_sgn;
                    exp_o      <= w_carry ? w_exp_r : w_exp_t;
                    mantissa_o <= w_carry ? '0 : w_man_r;
                    zero_o     <= 1'b0;
                    inexact_o  <= w_guard | w_sticky;
                end
                default: ;
            endcase
        end
    end

endmodule
